mem_access_unit: RTL and testbench

- MEM-stage responder to the decode control word: consumes mem_read / mem_write / word_size as carried through the EX/MEM register and performs one load or store per instruction against a byte-addressable data memory.
- Memory side uses a req/ack handshake.
- Aligns store data into byte lanes, extracts and extends load data, flags misaligned and illegal accesses, and stalls the pipeline while an access is in flight.

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_access_unit_load_extend.sv | 30 +++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access unit: word-size codes, FSM states, byte-enable patterns.
// Also imported by the decode stage so both agree on the word_size encoding.
package mem_access_unit_pkg;

  localparam logic [2:0] WORD_SIZE_WORD = 3'b000;
  localparam logic [2:0] WORD_SIZE_HALF = 3'b001;
  localparam logic [2:0] WORD_SIZE_BYTE = 3'b010;
  localparam int         WORD_SIZE_UNSIGNED_BIT = 2;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_kind_t;

  // Only the low two bits pick the width; the unused codes fold onto WORD.
  function automatic size_kind_t decode_size(input logic [1:0] size_lo);
    case (size_lo)
      2'b01:   decode_size = SZ_HALF;
      2'b10:   decode_size = SZ_BYTE;
      default: decode_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension (module mem_load_extend).
module mem_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_SIZE_TYPE = 3
) (
  input  logic [NB_DATA-1:0]      i_rdata,
  input  logic [1:0]              i_addr_lo,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  output logic [NB_DATA-1:0]      o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    w_byte   = i_rdata[8*i_addr_lo +: 8];
    w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_signed = ~i_word_size[WORD_SIZE_UNSIGNED_BIT];
    o_data   = i_rdata;
    case (decode_size(i_word_size[1:0]))
      SZ_HALF: o_data = {{(NB_DATA-16){w_signed & w_half[15]}}, w_half};
      SZ_BYTE: o_data = {{(NB_DATA-8){w_signed & w_byte[7]}}, w_byte};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder with req/ack data-memory handshake.
// Optional request watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_SIZE_TYPE = 3
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic [NB_DATA-1:0]      i_addr,
  input  logic [NB_DATA-1:0]      i_wdata,
  output logic                    o_dm_req,
  output logic                    o_dm_we,
  output logic [NB_DATA-3:0]      o_dm_addr,
  output logic [3:0]              o_dm_be,
  output logic [NB_DATA-1:0]      o_dm_wdata,
  input  logic                    i_dm_ack,
  input  logic [NB_DATA-1:0]      i_dm_rdata,
  output logic                    o_stall,
  output logic                    o_done,
  output logic                    o_rdata_valid,
  output logic [NB_DATA-1:0]      o_rdata,
  output logic                    o_misaligned,
  output logic                    o_error
);

  // Memory handshake: o_dm_req stays high through every REQ cycle and the
  // transfer completes on the first rising edge that sees i_dm_ack high;
  // ack outside REQ is ignored.
  state_t                  r_state, w_next;
  logic [NB_DATA-3:0]      r_dm_addr;
  logic [3:0]              r_dm_be;
  logic [NB_DATA-1:0]      r_dm_wdata;
  logic                    r_dm_we;
  logic [NB_SIZE_TYPE-1:0] r_word_size;
  logic [1:0]              r_addr_lo;
  logic [NB_DATA-1:0]      r_rdata;
  logic                    r_rdata_valid, r_misaligned, r_error;

  logic                    w_accept, w_conflict, w_misaligned, w_stall, w_timeout;
  size_kind_t              w_kind;
  logic [3:0]              w_be;
  logic [NB_DATA-1:0]      w_wdata, w_load_data;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [31:0] r_timeout_cnt;
  assign w_timeout = (r_timeout_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  mem_load_extend #(.NB_DATA(NB_DATA), .NB_SIZE_TYPE(NB_SIZE_TYPE)) u_load_extend (
    .i_rdata     (i_dm_rdata),
    .i_addr_lo   (r_addr_lo),
    .i_word_size (r_word_size),
    .o_data      (w_load_data)
  );

  always_comb begin
    w_accept     = i_valid & (i_mem_read | i_mem_write);
    w_conflict   = i_mem_read & i_mem_write;
    w_kind       = decode_size(i_word_size[1:0]);
    w_misaligned = ((w_kind == SZ_HALF) & i_addr[0]) |
                   ((w_kind == SZ_WORD) & (|i_addr[1:0]));
    w_wdata      = i_wdata;
    w_be         = BE_WORD;
    case (w_kind)
      SZ_BYTE: begin
        w_wdata = {(NB_DATA/8){i_wdata[7:0]}};
        w_be    = BE_BYTE0 << i_addr[1:0];
      end
      SZ_HALF: begin
        w_wdata = {(NB_DATA/16){i_wdata[15:0]}};
        w_be    = i_addr[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_stall = 1'b1;
        w_next  = (w_conflict | w_misaligned) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (i_dm_ack | w_timeout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Fault and valid flags are rewritten every edge, so they are high only in DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_dm_addr     <= '0;
      r_dm_be       <= '0;
      r_dm_wdata    <= '0;
      r_dm_we       <= 1'b0;
      r_word_size   <= '0;
      r_addr_lo     <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_error       <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      r_timeout_cnt <= '0;
`endif
    end else begin
      r_state       <= w_next;
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_error       <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          if (w_conflict) begin
            r_error <= 1'b1;
          end else if (w_misaligned) begin
            r_misaligned <= 1'b1;
          end else begin
            r_dm_addr   <= i_addr[NB_DATA-1:2];
            r_dm_be     <= w_be;
            r_dm_wdata  <= w_wdata;
            r_dm_we     <= i_mem_write;
            r_word_size <= i_word_size;
            r_addr_lo   <= i_addr[1:0];
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          r_timeout_cnt <= '0;
`endif
        end
        ST_REQ: begin
          if (i_dm_ack) begin
            if (!r_dm_we) begin
              r_rdata       <= w_load_data;
              r_rdata_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          if (!i_dm_ack) r_timeout_cnt <= r_timeout_cnt + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_dm_req      = (r_state == ST_REQ);
  assign o_done        = (r_state == ST_DONE);
  assign o_stall       = w_stall & ~i_reset;
  assign o_dm_we       = r_dm_we;
  assign o_dm_addr     = r_dm_addr;
  assign o_dm_be       = r_dm_be;
  assign o_dm_wdata    = r_dm_wdata;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_misaligned  = r_misaligned;
  assign o_error       = r_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, alignment faults, handshake timing, reset.
module tb_mem_access_unit;

  logic        i_clk = 1'b0, i_reset = 1'b1;
  logic        i_valid = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [2:0]  i_word_size = 3'b000;
  logic [31:0] i_addr = '0, i_wdata = '0, i_dm_rdata = '0;
  logic        i_dm_ack = 1'b0;
  logic        o_dm_req, o_dm_we, o_stall, o_done, o_rdata_valid, o_misaligned, o_error;
  logic [29:0] o_dm_addr;
  logic [3:0]  o_dm_be;
  logic [31:0] o_dm_wdata, o_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Observations captured by the single-access driver.
  logic        obs_stall0, obs_stall1, obs_stall2, obs_req, obs_we, obs_done, obs_rv;
  logic [29:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_rdata;

  mem_access_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_word_size(i_word_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be),
    .o_dm_wdata(o_dm_wdata), .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata), .o_stall(o_stall),
    .o_done(o_done), .o_rdata_valid(o_rdata_valid), .o_rdata(o_rdata),
    .o_misaligned(o_misaligned), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] ws,
                          input logic [31:0] addr, input logic [31:0] wdata);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
    i_word_size = ws; i_addr = addr; i_wdata = wdata;
  endtask

  task automatic clear_op();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_dm_ack = 1'b0;
  endtask

  // Accept, ack in the first REQ cycle, and stop at the DONE-cycle sample point.
  task automatic run_fast(input logic rd, input logic wr, input logic [2:0] ws,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    step(); drive_op(rd, wr, ws, addr, wdata);
    @(negedge i_clk); obs_stall0 = o_stall;
    step(); i_dm_ack = 1'b1; i_dm_rdata = rdata;
    @(negedge i_clk);
    obs_stall1 = o_stall; obs_req = o_dm_req; obs_we = o_dm_we;
    obs_addr = o_dm_addr; obs_be = o_dm_be; obs_wdata = o_dm_wdata;
    step(); clear_op();
    @(negedge i_clk);
    obs_stall2 = o_stall; obs_done = o_done; obs_rv = o_rdata_valid; obs_rdata = o_rdata;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) step();
    @(negedge i_clk);
    n_cmp++; if ({o_dm_req, o_dm_we, o_stall, o_done, o_rdata_valid, o_misaligned, o_error} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
        {o_dm_req, o_dm_we, o_stall, o_done, o_rdata_valid, o_misaligned, o_error}); end
    n_cmp++; if ({o_dm_addr, o_dm_be, o_dm_wdata, o_rdata} !== 98'd0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want all 0", o_dm_addr, o_dm_be, o_dm_wdata, o_rdata); end
    step(); i_reset = 1'b0;
  endtask

  task automatic test_ack_idle();
    i_dm_ack = 1'b1;
    repeat (2) begin
      step(); @(negedge i_clk);
      n_cmp++; if ({o_dm_req, o_done, o_rdata_valid, o_stall} !== 4'b0000) begin
        n_err++; $display("FAIL ack_idle: got req/done/rv/stall %b want 0000",
          {o_dm_req, o_done, o_rdata_valid, o_stall}); end
    end
    i_dm_ack = 1'b0;
  endtask

  task automatic test_store_word();
    run_fast(1'b0, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0);
    n_cmp++; if ({obs_stall0, obs_stall1, obs_stall2} !== 3'b110) begin
      n_err++; $display("FAIL sw_stall: got %b want 110", {obs_stall0, obs_stall1, obs_stall2}); end
    n_cmp++; if ({obs_req, obs_we, obs_be} !== 6'b11_1111) begin
      n_err++; $display("FAIL sw_req_we_be: got %b want 111111", {obs_req, obs_we, obs_be}); end
    n_cmp++; if (obs_addr !== 30'h4 || obs_wdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL sw_addr_data: got %h/%h want 4/deadbeef", obs_addr, obs_wdata); end
    n_cmp++; if ({obs_done, obs_rv, obs_rdata} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL sw_done: got done=%b rv=%b rdata=%h want 1/0/0", obs_done, obs_rv, obs_rdata); end
    step(); @(negedge i_clk);
    n_cmp++; if (o_done !== 1'b0) begin
      n_err++; $display("FAIL sw_done_pulse: got %b want 0", o_done); end
  endtask

  task automatic test_load_byte();
    run_fast(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 32'h80FF7F01);
    n_cmp++; if ({obs_req, obs_we, obs_addr} !== {2'b10, 30'h4}) begin
      n_err++; $display("FAIL lb_req: got req=%b we=%b addr=%h want 1/0/4", obs_req, obs_we, obs_addr); end
    n_cmp++; if ({obs_done, obs_rv, obs_rdata} !== {2'b11, 32'hFFFFFF80}) begin
      n_err++; $display("FAIL lb_data: got %b/%b/%h want 1/1/ffffff80", obs_done, obs_rv, obs_rdata); end
    run_fast(1'b1, 1'b0, 3'b110, 32'h13, 32'h0, 32'h80FF7F01);
    n_cmp++; if ({obs_rv, obs_rdata} !== {1'b1, 32'h00000080}) begin
      n_err++; $display("FAIL lbu_data: got %b/%h want 1/00000080", obs_rv, obs_rdata); end
    run_fast(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h80FF7F01);
    n_cmp++; if (obs_rdata !== 32'h00000001) begin
      n_err++; $display("FAIL lb_lane0: got %h want 00000001", obs_rdata); end
  endtask

  task automatic test_load_half();
    run_fast(1'b1, 1'b0, 3'b001, 32'h6, 32'h0, 32'h80011234);
    n_cmp++; if ({obs_addr, obs_rv, obs_rdata} !== {30'h1, 1'b1, 32'hFFFF8001}) begin
      n_err++; $display("FAIL lh_data: got addr=%h rv=%b rdata=%h want 1/1/ffff8001", obs_addr, obs_rv, obs_rdata); end
    run_fast(1'b1, 1'b0, 3'b101, 32'h4, 32'h0, 32'h80011234);
    n_cmp++; if (obs_rdata !== 32'h00001234) begin
      n_err++; $display("FAIL lhu_data: got %h want 00001234", obs_rdata); end
  endtask

  task automatic test_store_lanes();
    run_fast(1'b0, 1'b1, 3'b001, 32'h6, 32'h0000ABCD, 32'h0);
    n_cmp++; if ({obs_be, obs_wdata} !== {4'b1100, 32'hABCDABCD}) begin
      n_err++; $display("FAIL sh_lanes: got be=%b wdata=%h want 1100/abcdabcd", obs_be, obs_wdata); end
    n_cmp++; if ({obs_rv, obs_rdata} !== {1'b0, 32'h00001234}) begin
      n_err++; $display("FAIL sh_rdata_hold: got %b/%h want 0/00001234", obs_rv, obs_rdata); end
    run_fast(1'b0, 1'b1, 3'b010, 32'h5, 32'h00000012, 32'h0);
    n_cmp++; if ({obs_be, obs_wdata} !== {4'b0010, 32'h12121212}) begin
      n_err++; $display("FAIL sb_lanes: got be=%b wdata=%h want 0010/12121212", obs_be, obs_wdata); end
    run_fast(1'b0, 1'b1, 3'b001, 32'h0, 32'h00005678, 32'h0);
    n_cmp++; if (obs_be !== 4'b0011) begin
      n_err++; $display("FAIL sh_lo_be: got %b want 0011", obs_be); end
  endtask

  task automatic test_word_alias();
    run_fast(1'b1, 1'b0, 3'b011, 32'h8, 32'h0, 32'h12345678);
    n_cmp++; if ({obs_be, obs_rdata} !== {4'b1111, 32'h12345678}) begin
      n_err++; $display("FAIL ws011_word: got be=%b rdata=%h want 1111/12345678", obs_be, obs_rdata); end
    run_fast(1'b1, 1'b0, 3'b111, 32'hC, 32'h0, 32'h87654321);
    n_cmp++; if (obs_rdata !== 32'h87654321) begin
      n_err++; $display("FAIL ws111_word: got %h want 87654321", obs_rdata); end
  endtask

  // Fault paths: DONE at T+1, never a memory request.
  task automatic test_fault(input string name, input logic rd, input logic wr, input logic [2:0] ws,
                            input logic [31:0] addr, input logic exp_mis, input logic exp_err);
    step(); drive_op(rd, wr, ws, addr, 32'h0);
    @(negedge i_clk);
    n_cmp++; if ({o_stall, o_dm_req, o_done} !== 3'b100) begin
      n_err++; $display("FAIL %s_t0: got stall/req/done %b want 100", name, {o_stall, o_dm_req, o_done}); end
    step(); clear_op(); i_dm_ack = 1'b1;
    @(negedge i_clk);
    n_cmp++; if ({o_done, o_dm_req, o_stall, o_misaligned, o_error, o_rdata_valid} !== {3'b100, exp_mis, exp_err, 1'b0}) begin
      n_err++; $display("FAIL %s_t1: got done/req/stall/mis/err/rv %b want 100%b%b0",
        name, {o_done, o_dm_req, o_stall, o_misaligned, o_error, o_rdata_valid}, exp_mis, exp_err); end
    step(); i_dm_ack = 1'b0;
    @(negedge i_clk);
    n_cmp++; if ({o_done, o_dm_req, o_misaligned, o_error} !== 4'b0000) begin
      n_err++; $display("FAIL %s_t2: got done/req/mis/err %b want 0000", name, {o_done, o_dm_req, o_misaligned, o_error}); end
  endtask

  task automatic test_ack_delay();
    int stall_cycles;
    stall_cycles = 0;
    step(); drive_op(1'b1, 1'b0, 3'b000, 32'h20, 32'h0);
    @(negedge i_clk); if (o_stall) stall_cycles++;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 5) begin i_dm_ack = 1'b1; i_dm_rdata = 32'hCAFEF00D; end
      @(negedge i_clk); if (o_stall) stall_cycles++;
      if (k == 4) begin
        n_cmp++; if ({o_dm_req, o_done} !== 2'b10) begin
          n_err++; $display("FAIL delay_req_wait: got req/done %b want 10", {o_dm_req, o_done}); end
      end
    end
    step(); clear_op();
    @(negedge i_clk);
    n_cmp++; if (stall_cycles !== 6) begin
      n_err++; $display("FAIL delay_stall_len: got %0d want 6", stall_cycles); end
    n_cmp++; if ({o_done, o_stall, o_rdata_valid, o_rdata} !== {3'b101, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL delay_done: got %b/%b/%b/%h want 1/0/1/cafef00d", o_done, o_stall, o_rdata_valid, o_rdata); end
  endtask

  task automatic test_reset_in_req();
    step(); drive_op(1'b0, 1'b1, 3'b000, 32'h40, 32'h11223344);
    for (int k = 1; k <= 3; k++) step();
    i_reset = 1'b1; clear_op();
    @(negedge i_clk);
    n_cmp++; if (o_dm_req !== 1'b1) begin
      n_err++; $display("FAIL rst_req_before: got %b want 1", o_dm_req); end
    step(); i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      n_cmp++; if ({o_dm_req, o_done, o_stall, o_error} !== 4'b0000) begin
        n_err++; $display("FAIL rst_in_req_%0d: got req/done/stall/err %b want 0000", k, {o_dm_req, o_done, o_stall, o_error}); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_ack_idle();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_store_lanes();
    test_word_alias();
    test_fault("lw_misaligned", 1'b1, 1'b0, 3'b000, 32'h2, 1'b1, 1'b0);
    test_fault("lh_misaligned", 1'b1, 1'b0, 3'b001, 32'h3, 1'b1, 1'b0);
    test_fault("rw_conflict",   1'b1, 1'b1, 3'b000, 32'h2, 1'b0, 1'b1);
    test_ack_delay();
    test_reset_in_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
